// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset controller FSM with condition-gated write enables
// Optional MC_NOWRITE_EN: CMP/TST return from execute straight to FETCH, skipping ALUWB.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       FlagWEn,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] State
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  logic [3:0] state_q, state_d;
  logic       irw, pc_inc, reg_w, mem_w, branch, no_wb, rd_pc;

`ifdef MC_NOWRITE_EN
  assign no_wb = (Funct[4:1] == 4'b1010) || (Funct[4:1] == 4'b1000);
`else
  logic unused_funct;
  assign unused_funct = &{1'b0, Funct[4:1]};
  assign no_wb = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:             state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:              state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = no_wb ? FETCH : ALUWB;
      default:            state_d = FETCH;
    endcase
  end

  // Moore part: datapath selects and raw write requests per state.
  always_comb begin
    irw       = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    FlagWEn   = 1'b0;
    pc_inc    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    case (state_q)
      FETCH: begin
        irw = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_inc = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01; reg_w = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1; mem_w = 1'b1;
      end
      EXECUTER: begin
        ALUOp = 1'b1; FlagWEn = Funct[0] & CondEx;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01; ALUOp = 1'b1; FlagWEn = Funct[0] & CondEx;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
      end
      default: ;
    endcase
  end

  // A write-back to R15 becomes a PC write instead of a register-file write.
  assign rd_pc    = (Rd == 4'hF);
  assign IRWrite  = irw & ~reset;
  assign RegWrite = reg_w & CondEx & ~rd_pc;
  assign MemWrite = mem_w & CondEx;
  assign PCWrite  = (pc_inc & ~reset) | (reg_w & CondEx & rd_pc) | (branch & CondEx);
  assign State    = state_q;

endmodule
